// File: rtl/cpu_pipe_pkg.sv
// Shared widths and control-word field positions for the 5-stage CPU pipeline.
// Control word layout (bit 0 first): brz, brn, j, regw, wai, memw, memr, alusrc, aluop[2:0].
package cpu_pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 6;
    localparam int unsigned CTRL_W     = 11;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam int unsigned CTRL_BRZ       = 0;
    localparam int unsigned CTRL_BRN       = 1;
    localparam int unsigned CTRL_J         = 2;
    localparam int unsigned CTRL_REGW      = 3;
    localparam int unsigned CTRL_WAI       = 4;
    localparam int unsigned CTRL_MEMW      = 5;
    localparam int unsigned CTRL_MEMR      = 6;
    localparam int unsigned CTRL_ALUSRC    = 7;
    localparam int unsigned CTRL_ALUOP_LSB = 8;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: a load in EX whose destination is read
// by the instruction currently in ID.
module load_use_detect
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned REG_AW      = REG_AW_DEF,
    parameter int unsigned ZERO_REG_HW = 1
) (
    input  logic              ex_valid_i,
    input  logic              ex_memr_i,
    input  logic              ex_regw_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    output logic              haz_o
);

    logic rd_is_zero_reg;
    logic rs_hit;
    logic rt_hit;

    // A hardwired zero register is never really written, so it cannot be a hazard.
    assign rd_is_zero_reg = (ZERO_REG_HW != 0) && (ex_rd_i == '0);

    assign rs_hit = id_rs_used_i && (id_rs_i == ex_rd_i) && !rd_is_zero_reg;
    assign rt_hit = id_rt_used_i && (id_rt_i == ex_rd_i) && !rd_is_zero_reg;

    assign haz_o = ex_valid_i && ex_memr_i && ex_regw_i && id_valid_i && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, hold, branch flush, load-use bubble
// insertion and a saturating bubble counter.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W      = cpu_pipe_pkg::DATA_W_DEF,
    parameter int unsigned REG_AW      = cpu_pipe_pkg::REG_AW_DEF,
    parameter int unsigned CTRL_W      = cpu_pipe_pkg::CTRL_W,
    parameter int unsigned CNT_W       = cpu_pipe_pkg::CNT_W_DEF,
    parameter int unsigned ZERO_REG_HW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_rd1_i,
    input  logic [DATA_W-1:0] id_rd2_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_rd1_o,
    output logic [DATA_W-1:0] ex_rd2_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              stall_id_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);
    import cpu_pipe_pkg::*;

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] pc_q,    pc_d;
    logic [DATA_W-1:0] imm_q,   imm_d;
    logic [DATA_W-1:0] rd1_q,   rd1_d;
    logic [DATA_W-1:0] rd2_q,   rd2_d;
    logic [REG_AW-1:0] rs_q,    rs_d;
    logic [REG_AW-1:0] rt_q,    rt_d;
    logic [REG_AW-1:0] rd_q,    rd_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              haz;

    load_use_detect #(
        .REG_AW      (REG_AW),
        .ZERO_REG_HW (ZERO_REG_HW)
    ) u_load_use_detect (
        .ex_valid_i   (valid_q),
        .ex_memr_i    (ctrl_q[CTRL_MEMR]),
        .ex_regw_i    (ctrl_q[CTRL_REGW]),
        .ex_rd_i      (rd_q),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_rs_used_i (id_rs_used_i),
        .id_rt_used_i (id_rt_used_i),
        .haz_o        (haz)
    );

    // Flush beats hold beats bubble beats load; flush and bubble keep the data fields.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (hold_i) begin
            valid_d = valid_q;
        end else if (haz) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            valid_d = id_valid_i;
            ctrl_d  = id_valid_i ? id_ctrl_i : '0;
            pc_d    = id_pc_i;
            imm_d   = id_imm_i;
            rd1_d   = id_rd1_i;
            rd2_d   = id_rd2_i;
            rs_d    = id_rs_i;
            rt_d    = id_rt_i;
            rd_d    = id_rd_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_id_o   = !rst && !flush_i && (hold_i || haz);
    assign ex_valid_o   = valid_q;
    assign ex_ctrl_o    = ctrl_q;
    assign ex_pc_o      = pc_q;
    assign ex_imm_o     = imm_q;
    assign ex_rd1_o     = rd1_q;
    assign ex_rd2_o     = rd2_q;
    assign ex_rs_o      = rs_q;
    assign ex_rt_o      = rt_q;
    assign ex_rd_o      = rd_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench: two DUTs (zero register hardwired / not) share stimulus and
// are compared against a behavioural model of the ID/EX register.
module tb_id_ex_pipe_reg;
    import cpu_pipe_pkg::*;

    typedef struct {
        bit          idv;
        logic [31:0] pc, imm, rd1, rd2;
        logic [5:0]  rs, rt, rd;
        bit          rsu, rtu;
        logic [10:0] ctrl;
        bit          hold, flush;
    } in_t;

    typedef struct {
        bit          v;
        logic [10:0] ctrl;
        logic [31:0] pc, imm, rd1, rd2;
        logic [5:0]  rs, rt, rd;
        int unsigned cnt;
    } st_t;

    typedef struct {
        bit  stall_a, stall_b;
        st_t a, b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold_i = 0, flush_i = 0, id_valid_i = 0, id_rs_used_i = 0, id_rt_used_i = 0;
    logic [31:0] id_pc_i = '0, id_imm_i = '0, id_rd1_i = '0, id_rd2_i = '0;
    logic [5:0]  id_rs_i = '0, id_rt_i = '0, id_rd_i = '0;
    logic [10:0] id_ctrl_i = '0;

    logic        a_valid, b_valid, a_stall, b_stall;
    logic [31:0] a_pc, a_imm, a_rd1, a_rd2, b_pc, b_imm, b_rd1, b_rd2;
    logic [5:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
    logic [10:0] a_ctrl, b_ctrl;
    logic [1:0]  a_cnt, b_cnt;

    exp_t q[$];
    st_t  ma, mb;
    st_t  zero_st;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(6), .CTRL_W(11), .CNT_W(2), .ZERO_REG_HW(1)) dut_a (
        .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_rd_i(id_rd_i), .id_ctrl_i(id_ctrl_i), .ex_valid_o(a_valid), .ex_pc_o(a_pc), .ex_imm_o(a_imm),
        .ex_rd1_o(a_rd1), .ex_rd2_o(a_rd2), .ex_rs_o(a_rs), .ex_rt_o(a_rt), .ex_rd_o(a_rd),
        .ex_ctrl_o(a_ctrl), .stall_id_o(a_stall), .bubble_cnt_o(a_cnt)
    );

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(6), .CTRL_W(11), .CNT_W(2), .ZERO_REG_HW(0)) dut_b (
        .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
        .id_pc_i(id_pc_i), .id_imm_i(id_imm_i), .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rs_used_i(id_rs_used_i), .id_rt_used_i(id_rt_used_i),
        .id_rd_i(id_rd_i), .id_ctrl_i(id_ctrl_i), .ex_valid_o(b_valid), .ex_pc_o(b_pc), .ex_imm_o(b_imm),
        .ex_rd1_o(b_rd1), .ex_rd2_o(b_rd2), .ex_rs_o(b_rs), .ex_rt_o(b_rt), .ex_rd_o(b_rd),
        .ex_ctrl_o(b_ctrl), .stall_id_o(b_stall), .bubble_cnt_o(b_cnt)
    );

    // A load sits in EX and the ID instruction reads its destination register.
    function automatic bit hazard(st_t s, in_t x, bit zh);
        bit load_in_ex = s.v && s.ctrl[CTRL_MEMR] && s.ctrl[CTRL_REGW];
        bit reads_dst  = (x.rsu && x.rs == s.rd) || (x.rtu && x.rt == s.rd);
        bit zero_dst   = zh && (s.rd == 6'd0);
        return load_in_ex && x.idv && reads_dst && !zero_dst;
    endfunction

    function automatic st_t next_state(st_t s, in_t x, bit zh);
        st_t n = s;
        if (x.flush) begin
            n.v    = 1'b0;
            n.ctrl = '0;
        end else if (!x.hold) begin
            if (hazard(s, x, zh)) begin
                n.v    = 1'b0;
                n.ctrl = '0;
                n.cnt  = (s.cnt + 1 > 3) ? 3 : s.cnt + 1;
            end else begin
                n.v    = x.idv;
                n.ctrl = x.idv ? x.ctrl : 11'h000;
                n.pc   = x.pc;
                n.imm  = x.imm;
                n.rd1  = x.rd1;
                n.rd2  = x.rd2;
                n.rs   = x.rs;
                n.rt   = x.rt;
                n.rd   = x.rd;
            end
        end
        return n;
    endfunction

    function automatic in_t instr(bit idv, logic [5:0] rs, logic [5:0] rt, bit rsu, bit rtu,
                                  logic [5:0] rd, logic [10:0] ctrl);
        in_t x;
        x.idv = idv;   x.rs = rs;   x.rt = rt;   x.rsu = rsu; x.rtu = rtu;
        x.rd = rd;     x.ctrl = ctrl;
        x.pc = $urandom; x.imm = $urandom; x.rd1 = $urandom; x.rd2 = $urandom;
        x.hold = 1'b0; x.flush = 1'b0;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_st(string t, st_t s, logic v, logic [10:0] c, logic [31:0] pc, logic [31:0] imm,
                          logic [31:0] r1, logic [31:0] r2, logic [5:0] rs, logic [5:0] rt,
                          logic [5:0] rd, logic [1:0] cnt);
        check({t, "_valid"}, 32'(v),   32'(s.v));
        check({t, "_ctrl"},  32'(c),   32'(s.ctrl));
        check({t, "_pc"},    pc,       s.pc);
        check({t, "_imm"},   imm,      s.imm);
        check({t, "_rd1"},   r1,       s.rd1);
        check({t, "_rd2"},   r2,       s.rd2);
        check({t, "_rs"},    32'(rs),  32'(s.rs));
        check({t, "_rt"},    32'(rt),  32'(s.rt));
        check({t, "_rd"},    32'(rd),  32'(s.rd));
        check({t, "_cnt"},   32'(cnt), s.cnt);
    endtask

    // One cycle of stimulus: drive ID inputs, record expected stall and next EX state.
    task automatic issue(in_t x);
        exp_t e;
        @(negedge clk);
        #1;
        rst          = 1'b0;
        hold_i       = x.hold;   flush_i      = x.flush;  id_valid_i = x.idv;
        id_pc_i      = x.pc;     id_imm_i     = x.imm;
        id_rd1_i     = x.rd1;    id_rd2_i     = x.rd2;
        id_rs_i      = x.rs;     id_rt_i      = x.rt;     id_rd_i    = x.rd;
        id_rs_used_i = x.rsu;    id_rt_used_i = x.rtu;    id_ctrl_i  = x.ctrl;
        e.stall_a = !x.flush && (x.hold || hazard(ma, x, 1'b1));
        e.stall_b = !x.flush && (x.hold || hazard(mb, x, 1'b0));
        e.a = next_state(ma, x, 1'b1);
        e.b = next_state(mb, x, 1'b0);
        q.push_back(e);
        ma = e.a;
        mb = e.b;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("stall_a", 32'(a_stall), 32'(e.stall_a));
                check("stall_b", 32'(b_stall), 32'(e.stall_b));
                @(posedge clk);
                #1;
                cmp_st("a", e.a, a_valid, a_ctrl, a_pc, a_imm, a_rd1, a_rd2, a_rs, a_rt, a_rd, a_cnt);
                cmp_st("b", e.b, b_valid, b_ctrl, b_pc, b_imm, b_rd1, b_rd2, b_rs, b_rt, b_rd, b_cnt);
            end
        end
    end

    initial begin : driver
        in_t x;
        zero_st = '{v: 1'b0, ctrl: '0, pc: '0, imm: '0, rd1: '0, rd2: '0, rs: '0, rt: '0, rd: '0, cnt: 0};
        ma = zero_st;
        mb = zero_st;
        #2;
        cmp_st("rst_a", zero_st, a_valid, a_ctrl, a_pc, a_imm, a_rd1, a_rd2, a_rs, a_rt, a_rd, a_cnt);
        check("rst_stall", 32'(a_stall), 32'd0);

        // Asynchronous reset between edges clears a freshly loaded instruction.
        x = instr(1, 6'd1, 6'd2, 1, 1, 6'd3, 11'h008);
        x.pc = 32'h40;
        issue(x);
        @(posedge clk);
        #2;
        rst = 1'b1;
        hold_i = 1'b1;
        #1;
        cmp_st("arst_a", zero_st, a_valid, a_ctrl, a_pc, a_imm, a_rd1, a_rd2, a_rs, a_rt, a_rd, a_cnt);
        cmp_st("arst_b", zero_st, b_valid, b_ctrl, b_pc, b_imm, b_rd1, b_rd2, b_rs, b_rt, b_rd, b_cnt);
        check("arst_stall", 32'(a_stall), 32'd0);
        ma = zero_st;
        mb = zero_st;

        // Load-use: lw r5, then dependent add stalls once and then loads.
        issue(instr(1, 6'd1, 6'd2, 1, 0, 6'd5, 11'h048));
        x = instr(1, 6'd5, 6'd9, 1, 0, 6'd6, 11'h008);
        issue(x);
        issue(x);

        // Filtering: rs not used; destination r0.
        issue(instr(1, 6'd1, 6'd2, 1, 0, 6'd5, 11'h048));
        issue(instr(1, 6'd5, 6'd7, 0, 1, 6'd6, 11'h008));
        issue(instr(1, 6'd1, 6'd2, 1, 0, 6'd0, 11'h048));
        x = instr(1, 6'd0, 6'd9, 1, 0, 6'd6, 11'h008);
        issue(x);
        issue(x);

        // Hold for three cycles while a hazard is also present.
        issue(instr(1, 6'd1, 6'd2, 1, 0, 6'd5, 11'h048));
        for (int i = 0; i < 3; i++) begin
            x = instr(1, 6'd5, 6'd5, 1, 1, 6'(i + 10), 11'(i + 1));
            x.hold = 1'b1;
            issue(x);
        end
        issue(instr(1, 6'd5, 6'd2, 1, 0, 6'd6, 11'h008));

        // Flush together with hold and hazard, then a normal load.
        issue(instr(1, 6'd1, 6'd2, 1, 0, 6'd5, 11'h048));
        x = instr(1, 6'd5, 6'd2, 1, 0, 6'd6, 11'h008);
        x.hold  = 1'b1;
        x.flush = 1'b1;
        issue(x);
        issue(instr(1, 6'd5, 6'd2, 1, 0, 6'd6, 11'h008));

        // Invalid ID slot next to a load: no hazard, loads as a bubble.
        issue(instr(1, 6'd1, 6'd2, 1, 0, 6'd5, 11'h048));
        issue(instr(0, 6'd5, 6'd5, 1, 1, 6'd6, 11'h7ff));

        // Counter saturation: five load-use pairs.
        for (int i = 0; i < 5; i++) begin
            issue(instr(1, 6'd1, 6'd2, 1, 0, 6'd5, 11'h048));
            x = instr(1, 6'd2, 6'd5, 0, 1, 6'd6, 11'h008);
            issue(x);
            issue(x);
        end

        for (int i = 0; i < 400; i++) begin
            x = instr($urandom_range(0, 9) != 0, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                      11'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                x.ctrl[CTRL_MEMR] = 1'b1;
                x.ctrl[CTRL_REGW] = 1'b1;
            end
            x.hold  = ($urandom_range(0, 7) == 0);
            x.flush = ($urandom_range(0, 9) == 0);
            issue(x);
        end

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #3;
        check("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
